// File: rtl/rom_burst_arbiter_if.sv
// Bus bundle between the burst arbiter, its two clients and the shared ROM.
// The master modport is the client/ROM side; the slave modport is the arbiter.
interface rom_burst_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] req_addr0;
    logic [LEN_W-1:0]  req_len0;
    logic [ADDR_W-1:0] req_addr1;
    logic [LEN_W-1:0]  req_len1;
    logic [1:0]        ack;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_read_en;
    logic              rom_ce;
    logic [DATA_W-1:0] rom_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_last;
    logic              busy;

    modport master (
        output req, req_addr0, req_len0, req_addr1, req_len1, rom_data,
        input  ack, rom_addr, rom_read_en, rom_ce,
        input  rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );

    modport slave (
        input  req, req_addr0, req_len0, req_addr1, req_len1, rom_data,
        output ack, rom_addr, rom_read_en, rom_ce,
        output rsp_valid, rsp_data, rsp_id, rsp_last, busy
    );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter sharing one asynchronous-read ROM between two
// requesters. Every output is a flop; ROM data is captured one cycle after
// the address is presented and returned tagged with the owning requester.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ROM parked (ce/read_en low); waiting for a request
// S_READ | burst in flight; ROM driven at start+cnt, one beat per cycle
module rom_burst_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input logic               clk,
    input logic               rst_n,
    rom_burst_arbiter_if.slave bus
);
    // One extra bit so a length field of 0 can hold 2^LEN_W beats.
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_ptr;
    logic              r_win;
    logic [ADDR_W-1:0] r_start;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_ack;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_en;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_id;
    logic              r_rsp_last;

    logic              w_req_any;
    logic              w_win;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [LEN_W-1:0]  w_len_raw;
    logic [CNT_W-1:0]  w_len_sel;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_is_last;
    logic [ADDR_W-1:0] w_next_addr;

    logic              w_ptr_nxt;
    logic              w_win_nxt;
    logic [ADDR_W-1:0] w_start_nxt;
    logic [CNT_W-1:0]  w_len_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        w_ack_nxt;
    logic [ADDR_W-1:0] w_rom_addr_nxt;
    logic              w_rom_en_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_data_nxt;
    logic              w_rsp_id_nxt;
    logic              w_rsp_last_nxt;

    // Winner selection and burst address/length arithmetic.
    always_comb begin
        w_req_any   = |bus.req;
        w_win       = (bus.req == 2'b10) ? 1'b1 :
                      (bus.req == 2'b01) ? 1'b0 : r_ptr;
        w_addr_sel  = w_win ? bus.req_addr1 : bus.req_addr0;
        w_len_raw   = w_win ? bus.req_len1  : bus.req_len0;
        w_len_sel   = {~|w_len_raw, w_len_raw};
        w_cnt_inc   = r_cnt + CNT_W'(1);
        w_is_last   = (r_cnt == (r_len - CNT_W'(1)));
        w_next_addr = r_start + ADDR_W'(w_cnt_inc);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_state_nxt = S_READ;
            S_READ:  if (w_is_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and burst bookkeeping.
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_win_nxt       = r_win;
        w_start_nxt     = r_start;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_ack_nxt       = 2'b00;
        w_rom_addr_nxt  = r_rom_addr;
        w_rom_en_nxt    = r_rom_en;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_last_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_win_nxt      = w_win;
                    w_start_nxt    = w_addr_sel;
                    w_len_nxt      = w_len_sel;
                    w_cnt_nxt      = '0;
                    w_ack_nxt      = w_win ? 2'b10 : 2'b01;
                    w_rom_addr_nxt = w_addr_sel;
                    w_rom_en_nxt   = 1'b1;
                end
            end
            S_READ: begin
                w_rsp_data_nxt  = bus.rom_data;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_id_nxt    = r_win;
                w_rsp_last_nxt  = w_is_last;
                w_cnt_nxt       = w_cnt_inc;
                w_rom_addr_nxt  = w_next_addr;
                if (w_is_last) begin
                    w_rom_en_nxt   = 1'b0;
                    w_rom_addr_nxt = '0;
                    w_ptr_nxt      = ~r_win;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= 1'b0;
            r_win       <= 1'b0;
            r_start     <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_ack       <= 2'b00;
            r_rom_addr  <= '0;
            r_rom_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_win       <= w_win_nxt;
            r_start     <= w_start_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ack       <= w_ack_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_rom_en    <= w_rom_en_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
        end
    end

    // ce and read_en share one flop so they can never disagree.
    assign bus.ack         = r_ack;
    assign bus.rom_addr    = r_rom_addr;
    assign bus.rom_read_en = r_rom_en;
    assign bus.rom_ce      = r_rom_en;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_last    = r_rsp_last;
    assign bus.busy        = (r_state == S_READ);
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter with a ROM model holding i ^ 8'hA5.
module tb_rom_burst_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] log_data [16];

    rom_burst_arbiter_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) bus ();

    rom_burst_arbiter #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = (bus.rom_ce && bus.rom_read_en) ? (bus.rom_addr ^ 8'hA5) : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},   32'(bus.ack),         0);
        check({tag, "_addr"},  32'(bus.rom_addr),    0);
        check({tag, "_rd"},    32'(bus.rom_read_en), 0);
        check({tag, "_ce"},    32'(bus.rom_ce),      0);
        check({tag, "_valid"}, 32'(bus.rsp_valid),   0);
        check({tag, "_data"},  32'(bus.rsp_data),    0);
        check({tag, "_id"},    32'(bus.rsp_id),      0);
        check({tag, "_last"},  32'(bus.rsp_last),    0);
        check({tag, "_busy"},  32'(bus.busy),        0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at the negedge of the cycle in which ack should be high.
    task automatic burst(input string tag, input logic id, input logic [7:0] start, input int len);
        check({tag, "_ack"}, 32'(bus.ack), id ? 32'd2 : 32'd1);
        for (int k = 0; k < len; k++) begin
            check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'(8'(start + k)));
            check({tag, "_rom_ce"},   32'(bus.rom_ce), 1);
            check({tag, "_rom_rd"},   32'(bus.rom_read_en), 1);
            check({tag, "_busy"},     32'(bus.busy), 1);
            if (k > 0) check({tag, "_ack_low"}, 32'(bus.ack), 0);
            @(negedge clk);
            check({tag, "_valid"}, 32'(bus.rsp_valid), 1);
            check({tag, "_id"},    32'(bus.rsp_id), 32'(id));
            check({tag, "_last"},  32'(bus.rsp_last), (k == len - 1) ? 32'd1 : 32'd0);
            check({tag, "_data"},  32'(bus.rsp_data), 32'(8'(start + k) ^ 8'hA5));
            log_data[k] = bus.rsp_data;
        end
        check({tag, "_end_ce"},   32'(bus.rom_ce), 0);
        check({tag, "_end_rd"},   32'(bus.rom_read_en), 0);
        check({tag, "_end_addr"}, 32'(bus.rom_addr), 0);
        check({tag, "_end_busy"}, 32'(bus.busy), 0);
        check({tag, "_end_ack"},  32'(bus.ack), 0);
    endtask

    initial begin
        bus.req = 2'b00;
        bus.req_addr0 = 8'h00; bus.req_len0 = 4'd1;
        bus.req_addr1 = 8'h00; bus.req_len1 = 4'd1;
        #1 check_zero("por");
        do_reset("rst0");

        // 1: single 3-beat burst from requester 0
        bus.req_addr0 = 8'h10; bus.req_len0 = 4'd3; bus.req = 2'b01;
        @(negedge clk); bus.req = 2'b00;
        burst("t1", 1'b0, 8'h10, 3);
        check("t1_b0", 32'(log_data[0]), 32'h B5);
        check("t1_b1", 32'(log_data[1]), 32'h B4);
        check("t1_b2", 32'(log_data[2]), 32'h B7);
        @(negedge clk);
        check("t1_valid_off", 32'(bus.rsp_valid), 0);
        check("t1_data_hold", 32'(bus.rsp_data), 32'h B7);
        check("t1_last_off",  32'(bus.rsp_last), 0);

        // 2: simultaneous requests from reset; pointer then favours requester 1
        do_reset("rst2");
        bus.req_addr0 = 8'h00; bus.req_len0 = 4'd1;
        bus.req_addr1 = 8'h01; bus.req_len1 = 4'd1;
        bus.req = 2'b11;
        @(negedge clk);
        burst("t2a", 1'b0, 8'h00, 1);
        check("t2a_data", 32'(log_data[0]), 32'h A5);
        @(negedge clk);
        burst("t2b", 1'b1, 8'h01, 1);
        check("t2b_data", 32'(log_data[0]), 32'h A4);
        @(negedge clk); bus.req = 2'b00;
        burst("t2c", 1'b0, 8'h00, 1);

        // 3: address wrap 0xFE..0x01
        bus.req_addr1 = 8'hFE; bus.req_len1 = 4'd4; bus.req = 2'b10;
        @(negedge clk); bus.req = 2'b00;
        burst("t3", 1'b1, 8'hFE, 4);
        check("t3_b0", 32'(log_data[0]), 32'h 5B);
        check("t3_b1", 32'(log_data[1]), 32'h 5A);
        check("t3_b2", 32'(log_data[2]), 32'h A5);
        check("t3_b3", 32'(log_data[3]), 32'h A4);

        // 4: length field 0 means 16 beats
        bus.req_addr0 = 8'h20; bus.req_len0 = 4'd0; bus.req = 2'b01;
        @(negedge clk); bus.req = 2'b00;
        burst("t4", 1'b0, 8'h20, 16);
        check("t4_b0",  32'(log_data[0]),  32'h 85);
        check("t4_b15", 32'(log_data[15]), 32'h 8A);

        // 5: both held continuously, len 2: grants 0,1,0,1 with one idle ROM cycle
        do_reset("rst5");
        bus.req_addr0 = 8'h30; bus.req_len0 = 4'd2;
        bus.req_addr1 = 8'h50; bus.req_len1 = 4'd2;
        bus.req = 2'b11;
        @(negedge clk);
        burst("t5a", 1'b0, 8'h30, 2);
        @(negedge clk);
        burst("t5b", 1'b1, 8'h50, 2);
        @(negedge clk);
        burst("t5c", 1'b0, 8'h30, 2);
        @(negedge clk); bus.req = 2'b00;
        burst("t5d", 1'b1, 8'h50, 2);
        check("t5d_b1", 32'(log_data[1]), 32'h F4);

        // 6: reset in the middle of a 5-beat burst
        do_reset("rst6");
        bus.req_addr0 = 8'h40; bus.req_len0 = 4'd5; bus.req = 2'b01;
        @(negedge clk); bus.req = 2'b00;
        check("t6_ack", 32'(bus.ack), 1);
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_valid", 32'(bus.rsp_valid), 1);
        check("t6_pre_data",  32'(bus.rsp_data), 32'h E4);
        check("t6_pre_addr",  32'(bus.rom_addr), 32'h 42);
        #2 rst_n = 1'b0;
        #1 check_zero("t6_async");
        @(negedge clk);
        check("t6_hold_valid", 32'(bus.rsp_valid), 0);
        rst_n = 1'b1;
        bus.req_addr0 = 8'h60; bus.req_len0 = 4'd2;
        @(negedge clk);
        check("t6_post_valid0", 32'(bus.rsp_valid), 0);
        check("t6_post_busy0",  32'(bus.busy), 0);
        @(negedge clk);
        check("t6_post_valid1", 32'(bus.rsp_valid), 0);
        check("t6_post_ce1",    32'(bus.rom_ce), 0);
        bus.req = 2'b01;
        @(negedge clk); bus.req = 2'b00;
        burst("t6n", 1'b0, 8'h60, 2);
        check("t6n_b0", 32'(log_data[0]), 32'h C5);
        check("t6n_b1", 32'(log_data[1]), 32'h C4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
